// File: rtl/interrupt_priority_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_pkg
// Brief    : Field positions of the interrupt instruction word and the
//            grant sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
package interrupt_pkg;

    localparam int          OPCODE_HI  = 31;
    localparam int          OPCODE_LO  = 30;
    localparam logic [1:0]  INT_OPCODE = 2'b10;
    localparam int          PRIO_HI    = 29;
    localparam int          PRIO_LO    = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/interrupt_priority_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_priority_controller_if
// Brief    : Source-side and control-unit-side signals of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface interrupt_priority_controller_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_WIDTH   = 20,
    parameter int PRIO_WIDTH   = 5
);
    localparam int CH_WIDTH = $clog2(NUM_CHANNELS);

    logic [NUM_CHANNELS*WORD_SIZE-1:0] interrupt_word;
    logic [NUM_CHANNELS-1:0]           interrupt_valid;
    logic [NUM_CHANNELS-1:0]           interrupt_mask;
    logic                              interrupt_disable;
    logic                              interrupt_ack;
    logic                              interrupt_done;
    logic                              interrupt_request;
    logic [ADDR_WIDTH-1:0]             interrupt_address;
    logic [CH_WIDTH-1:0]               interrupt_channel;
    logic [PRIO_WIDTH-1:0]             interrupt_priority;
    logic [NUM_CHANNELS-1:0]           interrupt_pending;
    logic                              interrupt_in_service;

    // Sources and control unit side
    modport master (
        output interrupt_word, interrupt_valid, interrupt_mask,
               interrupt_disable, interrupt_ack, interrupt_done,
        input  interrupt_request, interrupt_address, interrupt_channel,
               interrupt_priority, interrupt_pending, interrupt_in_service
    );

    // Controller side
    modport slave (
        input  interrupt_word, interrupt_valid, interrupt_mask,
               interrupt_disable, interrupt_ack, interrupt_done,
        output interrupt_request, interrupt_address, interrupt_channel,
               interrupt_priority, interrupt_pending, interrupt_in_service
    );

endinterface
`default_nettype wire

// File: rtl/interrupt_priority_controller_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_priority_arbiter
// Brief    : Combinational highest-priority pick; ties go to the lowest index.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_priority_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int PRIO_WIDTH   = 5,
    parameter int CH_WIDTH     = $clog2(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0]            eligible_i,
    input  logic [NUM_CHANNELS*PRIO_WIDTH-1:0] prio_i,
    output logic [CH_WIDTH-1:0]                win_idx_o,
    output logic                               win_valid_o
);

    logic [PRIO_WIDTH-1:0] w_best_prio;

    // Strict '>' keeps the earlier (lower) index on equal priority.
    always_comb begin
        w_best_prio = '0;
        win_idx_o   = '0;
        win_valid_o = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (eligible_i[i] &&
                (!win_valid_o || (prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > w_best_prio))) begin
                w_best_prio = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
                win_idx_o   = CH_WIDTH'(i);
                win_valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_priority_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_priority_controller
// Brief    : Latches per-channel interrupt words, arbitrates by priority and
//            hands one winner at a time to the control unit.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_priority_controller
    import interrupt_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_WIDTH   = 20,
    parameter int PRIO_WIDTH   = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    interrupt_priority_controller_if.slave   irq_bus
);

    localparam int CH_WIDTH = $clog2(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0]            pending_q, pending_d;
    logic [NUM_CHANNELS*ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_CHANNELS*PRIO_WIDTH-1:0] prio_q, prio_d;

    state_t                 state_q, state_d;
    logic                   request_q, request_d;
    logic                   in_service_q, in_service_d;
    logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
    logic [CH_WIDTH-1:0]    out_chan_q, out_chan_d;
    logic [PRIO_WIDTH-1:0]  out_prio_q, out_prio_d;

    logic [NUM_CHANNELS-1:0] w_capture;
    logic [NUM_CHANNELS-1:0] w_eligible;
    logic [CH_WIDTH-1:0]     w_win_idx;
    logic                    w_win_valid;
    logic                    w_ack_accept;
    logic [NUM_CHANNELS-1:0] w_unused_word;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_capture
            assign w_capture[gi] = irq_bus.interrupt_valid[gi] &&
                (irq_bus.interrupt_word[gi*WORD_SIZE+OPCODE_LO +: 2] == INT_OPCODE);
            assign w_unused_word[gi] = ^irq_bus.interrupt_word[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    assign w_eligible   = pending_q & irq_bus.interrupt_mask;
    assign w_ack_accept = (state_q == REQUEST) && irq_bus.interrupt_ack;

    interrupt_priority_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .PRIO_WIDTH   (PRIO_WIDTH),
        .CH_WIDTH     (CH_WIDTH)
    ) u_arbiter (
        .eligible_i  (w_eligible),
        .prio_i      (prio_q),
        .win_idx_o   (w_win_idx),
        .win_valid_o (w_win_valid)
    );

    // A capture is applied after the ack clear so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        addr_d    = addr_q;
        prio_d    = prio_q;
        if (w_ack_accept) begin
            pending_d[out_chan_q] = 1'b0;
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_capture[i]) begin
                pending_d[i] = 1'b1;
                addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    irq_bus.interrupt_word[i*WORD_SIZE +: ADDR_WIDTH];
                prio_d[i*PRIO_WIDTH +: PRIO_WIDTH] =
                    irq_bus.interrupt_word[i*WORD_SIZE+PRIO_LO +: PRIO_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        request_d    = request_q;
        in_service_d = in_service_q;
        out_addr_d   = out_addr_q;
        out_chan_d   = out_chan_q;
        out_prio_d   = out_prio_q;
        case (state_q)
            IDLE: begin
                if (w_win_valid && !irq_bus.interrupt_disable) begin
                    state_d    = REQUEST;
                    request_d  = 1'b1;
                    out_addr_d = addr_q[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    out_chan_d = w_win_idx;
                    out_prio_d = prio_q[w_win_idx*PRIO_WIDTH +: PRIO_WIDTH];
                end
            end
            REQUEST: begin
                if (irq_bus.interrupt_ack) begin
                    state_d      = SERVICE;
                    request_d    = 1'b0;
                    in_service_d = 1'b1;
                end else if (irq_bus.interrupt_disable) begin
                    // Withdrawn grant leaves the presented fields cleared.
                    state_d    = IDLE;
                    request_d  = 1'b0;
                    out_addr_d = '0;
                    out_chan_d = '0;
                    out_prio_d = '0;
                end
            end
            SERVICE: begin
                if (irq_bus.interrupt_done) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                    out_addr_d   = '0;
                    out_chan_d   = '0;
                    out_prio_d   = '0;
                end
            end
            default: begin
                state_d      = IDLE;
                request_d    = 1'b0;
                in_service_d = 1'b0;
                out_addr_d   = '0;
                out_chan_d   = '0;
                out_prio_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            addr_q       <= '0;
            prio_q       <= '0;
            state_q      <= IDLE;
            request_q    <= 1'b0;
            in_service_q <= 1'b0;
            out_addr_q   <= '0;
            out_chan_q   <= '0;
            out_prio_q   <= '0;
        end else begin
            pending_q    <= pending_d;
            addr_q       <= addr_d;
            prio_q       <= prio_d;
            state_q      <= state_d;
            request_q    <= request_d;
            in_service_q <= in_service_d;
            out_addr_q   <= out_addr_d;
            out_chan_q   <= out_chan_d;
            out_prio_q   <= out_prio_d;
        end
    end

    assign irq_bus.interrupt_request    = request_q;
    assign irq_bus.interrupt_address    = out_addr_q;
    assign irq_bus.interrupt_channel    = out_chan_q;
    assign irq_bus.interrupt_priority   = out_prio_q;
    assign irq_bus.interrupt_pending    = pending_q;
    assign irq_bus.interrupt_in_service = in_service_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_priority_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_priority_controller
// Brief    : Directed and random stimulus against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_priority_controller;

    localparam int N = 4;
    localparam int W = 32;
    localparam int A = 20;
    localparam int P = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    interrupt_priority_controller_if #(
        .NUM_CHANNELS(N), .WORD_SIZE(W), .ADDR_WIDTH(A), .PRIO_WIDTH(P)
    ) bus ();

    interrupt_priority_controller #(
        .NUM_CHANNELS(N), .WORD_SIZE(W), .ADDR_WIDTH(A), .PRIO_WIDTH(P)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit         m_pend [N];
    logic [A-1:0] m_a  [N];
    logic [P-1:0] m_p  [N];
    int         m_mode;            // 0 waiting, 1 presenting, 2 servicing
    bit         m_req, m_isv;
    logic [A-1:0] m_addr;
    logic [1:0] m_ch;
    logic [P-1:0] m_pr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_a[i] = '0; m_p[i] = '0;
        end
        m_mode = 0; m_req = 0; m_isv = 0;
        m_addr = '0; m_ch = '0; m_pr = '0;
    endtask

    function automatic int pick_winner();
        int best = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && bus.interrupt_mask[i] && int'(m_p[i]) > best) best = int'(m_p[i]);
        for (int i = 0; i < N; i++)
            if (m_pend[i] && bus.interrupt_mask[i] && int'(m_p[i]) == best) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [W-1:0] wd;
        int w;
        case (m_mode)
            0: begin
                w = pick_winner();
                if (w >= 0 && !bus.interrupt_disable) begin
                    m_mode = 1; m_req = 1;
                    m_addr = m_a[w]; m_ch = 2'(w); m_pr = m_p[w];
                end
            end
            1: begin
                if (bus.interrupt_ack) begin
                    m_pend[m_ch] = 0; m_req = 0; m_isv = 1; m_mode = 2;
                end else if (bus.interrupt_disable) begin
                    m_req = 0; m_mode = 0; m_addr = '0; m_ch = '0; m_pr = '0;
                end
            end
            default: begin
                if (bus.interrupt_done) begin
                    m_isv = 0; m_mode = 0; m_addr = '0; m_ch = '0; m_pr = '0;
                end
            end
        endcase
        for (int i = 0; i < N; i++) begin
            wd = bus.interrupt_word[i*W +: W];
            if (bus.interrupt_valid[i] && wd[31:30] == 2'b10) begin
                m_pend[i] = 1; m_a[i] = wd[19:0]; m_p[i] = wd[29:25];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        logic [N-1:0] pv;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) pv[i] = m_pend[i];
            chk("cmp_request",    32'(bus.interrupt_request),    32'(m_req));
            chk("cmp_address",    32'(bus.interrupt_address),    32'(m_addr));
            chk("cmp_channel",    32'(bus.interrupt_channel),    32'(m_ch));
            chk("cmp_priority",   32'(bus.interrupt_priority),   32'(m_pr));
            chk("cmp_pending",    32'(bus.interrupt_pending),    32'(pv));
            chk("cmp_in_service", 32'(bus.interrupt_in_service), 32'(m_isv));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_word(input int ch, input logic [1:0] op, input logic [4:0] pr, input logic [19:0] ad);
        bus.interrupt_word[ch*W +: W] = {op, pr, 5'd0, ad};
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!bus.interrupt_request && k < 20) begin
            cyc(1);
            k++;
        end
        if (!bus.interrupt_request) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: request timeout, got 0 expected 1", name);
        end
    endtask

    task automatic serve(input string name, input logic [1:0] ch);
        wait_req(name);
        chk(name, 32'(bus.interrupt_channel), 32'(ch));
        bus.interrupt_ack = 1'b1;
        cyc(1);
        bus.interrupt_ack  = 1'b0;
        bus.interrupt_done = 1'b1;
        cyc(1);
        bus.interrupt_done = 1'b0;
    endtask

    initial begin
        bus.interrupt_word    = '0;
        bus.interrupt_valid   = '0;
        bus.interrupt_mask    = '1;
        bus.interrupt_disable = 1'b0;
        bus.interrupt_ack     = 1'b0;
        bus.interrupt_done    = 1'b0;
        #2 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        chk("reset_request", 32'(bus.interrupt_request), 32'd0);
        chk("reset_pending", 32'(bus.interrupt_pending), 32'd0);

        // Single source on channel 2
        set_word(2, 2'b10, 5'd7, 20'h0ABCD);
        bus.interrupt_valid = 4'b0100;
        cyc(1);
        bus.interrupt_valid = '0;
        chk("single_pending", 32'(bus.interrupt_pending), 32'h4);
        chk("single_req_early", 32'(bus.interrupt_request), 32'd0);
        cyc(1);
        chk("single_request", 32'(bus.interrupt_request), 32'd1);
        chk("single_address", 32'(bus.interrupt_address), 32'h0ABCD);
        chk("single_channel", 32'(bus.interrupt_channel), 32'd2);
        chk("single_priority", 32'(bus.interrupt_priority), 32'd7);
        bus.interrupt_ack = 1'b1;
        cyc(1);
        bus.interrupt_ack = 1'b0;
        chk("single_ack_pending", 32'(bus.interrupt_pending), 32'd0);
        chk("single_in_service", 32'(bus.interrupt_in_service), 32'd1);
        bus.interrupt_done = 1'b1;
        cyc(1);
        bus.interrupt_done = 1'b0;
        chk("single_done_isv", 32'(bus.interrupt_in_service), 32'd0);
        chk("single_done_addr", 32'(bus.interrupt_address), 32'd0);
        chk("single_done_chan", 32'(bus.interrupt_channel), 32'd0);

        // Priority and tie
        set_word(0, 2'b10, 5'd3, 20'h00100);
        set_word(1, 2'b10, 5'd9, 20'h00111);
        set_word(3, 2'b10, 5'd9, 20'h00333);
        bus.interrupt_valid = 4'b1011;
        cyc(1);
        bus.interrupt_valid = '0;
        cyc(1);
        serve("tie_first", 2'd1);
        serve("tie_second", 2'd3);
        serve("tie_third", 2'd0);

        // Mask and disable
        bus.interrupt_mask = 4'b1101;
        set_word(1, 2'b10, 5'd4, 20'h00011);
        bus.interrupt_valid = 4'b0010;
        cyc(1);
        bus.interrupt_valid = '0;
        cyc(3);
        chk("mask_no_request", 32'(bus.interrupt_request), 32'd0);
        chk("mask_pending", 32'(bus.interrupt_pending), 32'h2);
        bus.interrupt_mask = '1;
        cyc(1);
        chk("unmask_request", 32'(bus.interrupt_request), 32'd1);
        bus.interrupt_disable = 1'b1;
        cyc(1);
        chk("disable_request", 32'(bus.interrupt_request), 32'd0);
        chk("disable_pending", 32'(bus.interrupt_pending), 32'h2);
        bus.interrupt_disable = 1'b0;
        serve("disable_regrant", 2'd1);

        // No preemption
        set_word(0, 2'b10, 5'd2, 20'h00200);
        bus.interrupt_valid = 4'b0001;
        cyc(1);
        bus.interrupt_valid = '0;
        cyc(1);
        set_word(1, 2'b10, 5'd31, 20'h00FFF);
        bus.interrupt_valid = 4'b0010;
        cyc(1);
        bus.interrupt_valid = '0;
        cyc(2);
        chk("nopreempt_addr", 32'(bus.interrupt_address), 32'h00200);
        serve("nopreempt_first", 2'd0);
        wait_req("nopreempt_wait");
        chk("nopreempt_next_addr", 32'(bus.interrupt_address), 32'h00FFF);
        serve("nopreempt_second", 2'd1);

        // Same-cycle ack and recapture
        set_word(2, 2'b10, 5'd5, 20'h00010);
        bus.interrupt_valid = 4'b0100;
        cyc(1);
        bus.interrupt_valid = '0;
        wait_req("collide_wait");
        set_word(2, 2'b10, 5'd6, 20'h00042);
        bus.interrupt_valid = 4'b0100;
        bus.interrupt_ack   = 1'b1;
        cyc(1);
        bus.interrupt_valid = '0;
        bus.interrupt_ack   = 1'b0;
        chk("collide_pending", 32'(bus.interrupt_pending), 32'h4);
        chk("collide_isv", 32'(bus.interrupt_in_service), 32'd1);
        bus.interrupt_done = 1'b1;
        cyc(1);
        bus.interrupt_done = 1'b0;
        wait_req("collide_regrant");
        chk("collide_addr", 32'(bus.interrupt_address), 32'h00042);
        serve("collide_serve", 2'd2);
        set_word(3, 2'b01, 5'd9, 20'h00999);
        bus.interrupt_valid = 4'b1000;
        cyc(1);
        bus.interrupt_valid = '0;
        cyc(3);
        chk("bad_opcode_pending", 32'(bus.interrupt_pending), 32'd0);
        chk("bad_opcode_request", 32'(bus.interrupt_request), 32'd0);

        // Asynchronous reset during service
        set_word(1, 2'b10, 5'd1, 20'h00077);
        bus.interrupt_valid = 4'b0010;
        cyc(1);
        bus.interrupt_valid = '0;
        wait_req("rst_wait");
        bus.interrupt_ack = 1'b1;
        cyc(1);
        bus.interrupt_ack = 1'b0;
        chk("rst_pre_isv", 32'(bus.interrupt_in_service), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_isv", 32'(bus.interrupt_in_service), 32'd0);
        chk("rst_async_addr", 32'(bus.interrupt_address), 32'd0);
        chk("rst_async_chan", 32'(bus.interrupt_channel), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(3);
        chk("rst_after_request", 32'(bus.interrupt_request), 32'd0);
        chk("rst_after_pending", 32'(bus.interrupt_pending), 32'd0);

        // Random traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                set_word(i, ($urandom_range(3) == 0) ? 2'($urandom) : 2'b10,
                         5'($urandom), 20'($urandom));
                bus.interrupt_valid[i] = ($urandom_range(7) == 0);
                bus.interrupt_mask[i]  = ($urandom_range(7) != 0);
            end
            bus.interrupt_disable = ($urandom_range(15) == 0);
            bus.interrupt_ack     = ($urandom_range(2) == 0);
            bus.interrupt_done    = ($urandom_range(3) == 0);
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_priority_controller.md
Name: interrupt_priority_controller

Overview:
- N-channel successor to the two-input interrupt priority encoder. Latches 32-bit interrupt instruction words per channel and arbitrates by 5-bit priority.
- Presents one winner's 20-bit handler address to the control unit through a request/acknowledge handshake.
- Tracks in-service state until the handler signals completion.
- Sits between the peripheral/instruction interrupt sources and the control unit's PC-load logic.

Parameters:
- NUM_CHANNELS, 4, number of interrupt sources (2..16).
- WORD_SIZE, 32, interrupt instruction width.
- ADDR_WIDTH, 20, handler address width, taken from word bits [ADDR_WIDTH-1:0].
- PRIO_WIDTH, 5, priority field width, taken from word bits [29:25]. Larger value wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- interrupt_word  in  NUM_CHANNELS*WORD_SIZE  flattened instruction words; channel i is at [i*WORD_SIZE +: WORD_SIZE].
- interrupt_valid  in  NUM_CHANNELS  per-channel capture strobe, one cycle.
- interrupt_mask  in  NUM_CHANNELS  1 = channel eligible for arbitration.
- interrupt_disable  in  1  global arbitration inhibit, level.
- interrupt_ack  in  1  control unit accepts the presented request.
- interrupt_done  in  1  handler finished, one cycle.
- interrupt_request  out  1  winner presented.
- interrupt_address  out  ADDR_WIDTH  winner handler address.
- interrupt_channel  out  $clog2(NUM_CHANNELS)  winner index.
- interrupt_priority  out  PRIO_WIDTH  winner priority.
- interrupt_pending  out  NUM_CHANNELS  pending flags.
- interrupt_in_service  out  1  handler active.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all pending flags and stored words cleared, FSM in IDLE. Reset mid-handshake abandons the request with no residue.
- Capture: at a clock edge with interrupt_valid[i]=1 and word[31:30]==2'b10, pending[i]<=1 and addr[i]/prio[i] are stored. Any other opcode is ignored.
  - Capture on an already-pending channel overwrites its stored address and priority (latest wins).
  - If capture and ack-clear hit the same channel in the same cycle, the set wins and pending stays 1 with the new word.
- Eligibility: eligible[i] = pending[i] & interrupt_mask[i]. Masked pending channels stay pending.
- Arbitration: combinational over eligible channels. Highest prio wins; ties go to the lowest index; NUM_CHANNELS all equal selects channel 0 if eligible.
- FSM states:
  - IDLE: if any eligible and !interrupt_disable, register the winner's address, channel and priority and go to REQUEST. interrupt_request=1 from the next cycle.
  - REQUEST: outputs held stable; a higher-priority arrival does not displace the presented winner.
    - ack=1: pending[winner]<=0, request<=0, in_service<=1, go to SERVICE.
    - interrupt_disable=1 with ack=0: request<=0, back to IDLE, pending retained.
    - ack and disable together: ack wins.
  - SERVICE: no nesting; new captures only accumulate. done=1: in_service<=0, go to IDLE, and interrupt_address/channel/priority return to 0. done outside SERVICE is ignored.
- Latency: valid sampled at edge k, pending visible after k, request high after edge k+1 (2 cycles). After done at edge m, the next request is high after edge m+1 at earliest.
- interrupt_ack outside REQUEST is ignored.
- interrupt_disable in SERVICE does not abort service; it only blocks the next grant.

Decomposition:
- Shared package interrupt_pkg:
  - field constants OPCODE_HI=31, OPCODE_LO=30, INT_OPCODE=2'b10, PRIO_HI=29, PRIO_LO=25.
  - FSM state enum {IDLE, REQUEST, SERVICE}.
- One sub-module, interrupt_priority_arbiter: purely combinational. Inputs are the eligible vector plus the flattened priority vector; outputs are winner index and valid. Use a tie-breaking scan or tree parametrised by NUM_CHANNELS and PRIO_WIDTH.

Test Plan:
- Single source: ch2 word {2'b10, prio 5'd7, addr 20'h0ABCD} with valid at edge 0 -> request=1 after edge 1, address=20'h0ABCD, channel=2. ack -> pending[2]=0, in_service=1. done -> all outputs return to 0.
- Priority and tie: ch0 prio 3, ch1 prio 9, ch3 prio 9 captured together -> channel=1 granted first. After done, ch3 is granted, then ch0.
- Mask and disable: ch1 pending but mask[1]=0 -> no request. Raise mask -> request after 1 cycle. disable=1 in REQUEST -> request drops, pending[1] stays 1.
- No preemption: ch0 prio 2 in REQUEST, ch1 prio 31 arrives -> address stays ch0's until ack. ch1 is granted after done.
- Collisions: ack on ch2 with a same-cycle valid on ch2 (new addr 20'h00042) -> pending[2]=1; the next grant shows 20'h00042. A non-interrupt opcode 2'b01 -> ignored.
- Reset mid-SERVICE: assert rst_n=0 asynchronously -> all outputs 0 immediately. After release, no request until new captures.
